// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter
//   Shares one VGA framebuffer write port between NUM_REQ drawing engines.
//   Engines request ownership with a level req, are granted round-robin, and
//   keep the port for a whole drawing pass until they pulse done (or drop
//   req). The owner's pixel stream is registered onto the adapter port. A
//   watchdog revokes ownership after TIMEOUT consecutive write-free cycles.
//
// Ports
//   clock, resetn           clock, async active-low reset
//   req/done/wr_en          per-requester request level, end-of-pass pulse,
//                           pixel write strobe
//   x_in/y_in/colour_in     packed per-requester pixel (9/8/3 bits each)
//   grant                   one-hot owner, zero when no owner
//   writeEn/x/y/colour      registered pixel to the VGA adapter
//   busy                    owner present or releasing
//   timeout                 one-cycle pulse on watchdog revocation
module vga_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     done,
    input  logic [NUM_REQ-1:0]     wr_en,
    input  logic [9*NUM_REQ-1:0]   x_in,
    input  logic [8*NUM_REQ-1:0]   y_in,
    input  logic [3*NUM_REQ-1:0]   colour_in,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   writeEn,
    output logic [8:0]             x,
    output logic [7:0]             y,
    output logic [2:0]             colour,
    output logic                   busy,
    output logic                   timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_RELEASE} state_t;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] colour;
    } pix_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     owner, owner_nxt;
    logic [IW-1:0]     last_win, last_nxt;
    logic [CW-1:0]     wd_cnt;
    logic              to_nxt;

    // Per-requester pixel slices.
    pix_t [NUM_REQ-1:0] pix;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign pix[g].x      = x_in[9*g +: 9];
        assign pix[g].y      = y_in[8*g +: 8];
        assign pix[g].colour = colour_in[3*g +: 3];
    end

    // Owner's view of its own signals; everyone else is invisible here.
    pix_t own_pix;
    logic own_wr, own_done, own_req;

    always_comb begin
        own_pix  = '0;
        own_wr   = 1'b0;
        own_done = 1'b0;
        own_req  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IW'(i)) begin
                own_pix  = pix[i];
                own_wr   = wr_en[i];
                own_done = done[i];
                own_req  = req[i];
            end
        end
    end

    // Round-robin pick: first set req bit starting just after the last winner.
    logic [IW-1:0] win;
    logic          any_req;
    int            cand;

    always_comb begin
        win     = '0;
        any_req = 1'b0;
        cand    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_win) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!any_req && req[cand[IW-1:0]]) begin
                any_req = 1'b1;
                win     = cand[IW-1:0];
            end
        end
    end

    logic wr_term;
    assign wr_term = (state == S_OWN) && own_wr;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last_win;
        to_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt = S_OWN;
                    owner_nxt = win;
                    last_nxt  = win;
                end
            end
            S_OWN: begin
                // done/abort outrank the watchdog, so a coincident expiry
                // ends the pass normally without a timeout pulse.
                if (own_done || !own_req) begin
                    state_nxt = S_RELEASE;
                end else if (!own_wr && wd_cnt == CW'(TIMEOUT - 1)) begin
                    state_nxt = S_RELEASE;
                    to_nxt    = 1'b1;
                end
            end
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            owner    <= '0;
            last_win <= IW'(NUM_REQ - 1);
            wd_cnt   <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last_win <= last_nxt;
            timeout  <= to_nxt;
            // Held at zero outside S_OWN, so every pass starts from zero.
            if (state != S_OWN || own_wr) wd_cnt <= '0;
            else                          wd_cnt <= wd_cnt + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            writeEn <= 1'b0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
        end else begin
            writeEn <= wr_term;
            if (wr_term) begin
                x      <= own_pix.x;
                y      <= own_pix.y;
                colour <= own_pix.colour;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++)
            grant[i] = (state == S_OWN) && (owner == IW'(i));
    end

    assign busy = (state == S_OWN) || (state == S_RELEASE);

endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb_vga_write_arbiter
//   Directed steps followed by random traffic for vga_write_arbiter
//   (NUM_REQ=3, TIMEOUT=8). A pass-level reference model (current owner,
//   gap cycles, quiet-cycle count) predicts every output after each edge.
module tb_vga_write_arbiter;

    localparam int N  = 3;
    localparam int T  = 8;
    localparam int XW = 9 * N;
    localparam int YW = 8 * N;
    localparam int CCW = 3 * N;

    logic           clock = 1'b0;
    logic           resetn;
    logic [N-1:0]   req, done, wr_en;
    logic [XW-1:0]  x_in;
    logic [YW-1:0]  y_in;
    logic [CCW-1:0] colour_in;
    logic [N-1:0]   grant;
    logic           writeEn;
    logic [8:0]     x;
    logic [7:0]     y;
    logic [2:0]     colour;
    logic           busy;
    logic           timeout;

    vga_write_arbiter #(.NUM_REQ(N), .TIMEOUT(T)) dut (
        .clock(clock), .resetn(resetn), .req(req), .done(done), .wr_en(wr_en),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(grant),
        .writeEn(writeEn), .x(x), .y(y), .colour(colour), .busy(busy),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    int passes = 0;
    int checks = 0;

    // Reference model: who owns the port, how many gap cycles remain before
    // arbitration resumes, and how many write-free cycles the owner has had.
    int         m_owner, m_gap, m_last, m_quiet;
    logic       m_we, m_to;
    logic [8:0] m_x;
    logic [7:0] m_y;
    logic [2:0] m_c;

    int exp_g[4] = '{1, 2, 4, 1};
    int gap, cur, to_cnt, to_at;

    function automatic void model_reset();
        m_owner = -1; m_gap = 0; m_last = N - 1; m_quiet = 0;
        m_we = 1'b0; m_to = 1'b0; m_x = '0; m_y = '0; m_c = '0;
    endfunction

    function automatic void model_step();
        int o;
        m_we = 1'b0;
        m_to = 1'b0;
        if (m_owner >= 0) begin
            o = m_owner;
            if (wr_en[o]) begin
                m_we = 1'b1;
                m_x  = x_in[9*o +: 9];
                m_y  = y_in[8*o +: 8];
                m_c  = colour_in[3*o +: 3];
            end
            m_quiet = wr_en[o] ? 0 : m_quiet + 1;
            if (done[o] || !req[o]) begin
                m_owner = -1; m_gap = 1;
            end else if (m_quiet >= T) begin
                m_owner = -1; m_gap = 1; m_to = 1'b1;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (req != '0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (req[c]) begin
                    m_owner = c;
                    break;
                end
            end
            m_last  = m_owner;
            m_quiet = 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic compare_all();
        chk("grant",   32'(grant),   (m_owner >= 0) ? (1 << m_owner) : 0);
        chk("writeEn", 32'(writeEn), 32'(m_we));
        chk("x",       32'(x),       32'(m_x));
        chk("y",       32'(y),       32'(m_y));
        chk("colour",  32'(colour),  32'(m_c));
        chk("busy",    32'(busy),    32'((m_owner >= 0) || (m_gap > 0)));
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic step();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic set_pix(input int i, input int xv, input int yv, input int cv);
        x_in[9*i +: 9]      = 9'(xv);
        y_in[8*i +: 8]      = 8'(yv);
        colour_in[3*i +: 3] = 3'(cv);
    endtask

    initial begin
        resetn = 1'b0; req = '0; done = '0; wr_en = '0;
        x_in = '0; y_in = '0; colour_in = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        compare_all();
        chk("reset_outs", 32'({grant, writeEn, x, y, colour, busy, timeout}), 0);
        resetn = 1'b1;

        // Basic grant and pixel latency.
        req = 3'b001;
        step();
        chk("basic_grant", 32'(grant), 1);
        wr_en = 3'b001; set_pix(0, 5, 7, 4);
        step();
        chk("basic_pix", 32'({writeEn, x, y, colour}), 32'({1'b1, 9'd5, 8'd7, 3'd4}));

        // Reset in the middle of a pass clears outputs immediately.
        set_pix(0, 9, 9, 1);
        step();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("reset_mid", 32'({grant, writeEn, x, y, colour, busy, timeout}), 0);
        compare_all();
        @(posedge clock);
        #1;
        chk("reset_hold", 32'({grant, writeEn, busy}), 0);
        wr_en = '0; req = '0; resetn = 1'b1;

        // Round-robin with all three requesting, four writes per pass.
        req = 3'b111;
        for (int p = 0; p < 4; p++) begin
            gap = 0;
            while (grant == '0 && gap < 20) begin
                gap++;
                step();
            end
            if (p > 0) chk("rr_gap", gap, 2);
            chk("rr_grant", 32'(grant), exp_g[p]);
            cur = int'(grant);
            wr_en = N'(cur);
            for (int k = 0; k < 4; k++) begin
                x_in = XW'($urandom); y_in = YW'($urandom); colour_in = CCW'($urandom);
                step();
            end
            wr_en = '0; done = N'(cur);
            step();
            done = '0;
            if (p == 3) req = '0;
        end
        step(); step();

        // Isolation: requester 2 strobes and pulses done while 1 owns.
        req = 3'b110;
        step();
        chk("iso_grant", 32'(grant), 3'b010);
        for (int k = 0; k < 4; k++) begin
            wr_en = 3'b110;
            set_pix(1, 10 + k, 20, 2);
            set_pix(2, 300, 100, 7);
            done = (k == 1) ? 3'b100 : 3'b000;
            step();
            chk("iso_x", 32'(x), 10 + k);
            chk("iso_hold", 32'(grant), 3'b010);
        end
        wr_en = '0; done = 3'b010;
        step();
        done = '0; req = 3'b100;
        step(); step();
        chk("iso_next", 32'(grant), 3'b100);
        done = 3'b100;
        step();
        done = '0; req = '0;
        step(); step();

        // Watchdog: owner 0 writes once then stalls.
        req = 3'b011;
        step();
        chk("wd_grant", 32'(grant), 1);
        wr_en = 3'b001; set_pix(0, 1, 2, 3);
        step();
        wr_en = '0;
        to_cnt = 0; to_at = -1;
        for (int k = 1; k <= T; k++) begin
            step();
            if (timeout) begin to_cnt++; to_at = k; end
        end
        step();
        if (timeout) to_cnt++;
        chk("wd_pulses", to_cnt, 1);
        chk("wd_at", to_at, T);
        chk("wd_off", 32'(grant), 0);
        step();
        chk("wd_next", 32'(grant), 3'b010);

        // Abort: owner drops req, no timeout.
        req = '0;
        step();
        chk("abort_grant", 32'(grant), 0);
        chk("abort_to", 32'(timeout), 0);
        step();

        // Collision: wr_en + done on the cycle the watchdog would expire.
        req = 3'b001;
        step();
        chk("col_grant", 32'(grant), 1);
        repeat (T - 1) step();
        wr_en = 3'b001; done = 3'b001; set_pix(0, 319, 239, 5);
        step();
        chk("col_we", 32'(writeEn), 1);
        chk("col_x", 32'(x), 319);
        chk("col_to", 32'(timeout), 0);
        chk("col_rel", 32'({grant, busy}), 1);
        wr_en = '0; done = '0; req = '0;
        step(); step();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) req = N'($urandom);
            wr_en     = N'($urandom);
            done      = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            x_in      = XW'($urandom);
            y_in      = YW'($urandom);
            colour_in = CCW'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
